// File: rtl/qam_symbol_source.sv
// rtl/qam_symbol_source.sv - byte FIFO and 16-QAM symbol sequencer feeding the QAM stage
// Each buffered byte becomes two 4-bit symbols, each held for SAMPLES_PER_SYMBOL enabled clocks.

module qamByteFifo #(
  parameter int DEPTH = 4
) (
  input  logic                  ipClk,
  input  logic                  ipReset,
  input  logic                  ipPush,
  input  logic [7:0]            ipData,
  input  logic                  ipPop,
  output logic [7:0]            opData,
  output logic [$clog2(DEPTH):0] opCount,
  output logic [$clog2(DEPTH):0] opCountNext
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;

  // Storage carries no reset; discarding data on reset only needs the pointers cleared.
  always_ff @(posedge ipClk) begin
    if (ipPush) mem[wrPtr] <= ipData;
  end

  always_comb begin
    opCountNext = opCount;
    if (ipPush && !ipPop) opCountNext = opCount + 1'b1;
    else if (!ipPush && ipPop) opCountNext = opCount - 1'b1;
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      opCount <= '0;
    end else begin
      if (ipPush) wrPtr <= wrPtr + 1'b1;
      if (ipPop)  rdPtr <= rdPtr + 1'b1;
      opCount <= opCountNext;
    end
  end

  assign opData = mem[rdPtr];
endmodule

module qam_symbol_source #(
  parameter int SAMPLES_PER_SYMBOL = 8,
  parameter int FIFO_DEPTH         = 4,
  parameter bit MSB_FIRST          = 1'b1
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipData,
  input  logic       ipDataValid,
  output logic       opDataReady,
  input  logic       ipEnable,
  output logic [3:0] opQAMBlock,
  output logic       opQAMBlockValid,
  output logic       opSymbolStart,
  output logic       opBurstEnd
);
  localparam int CNT_W = $clog2(SAMPLES_PER_SYMBOL);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES_PER_SYMBOL - 1);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} stateT;

  stateT          state, stateNext;
  logic [CNT_W-1:0] sampleCount, sampleCountNext;
  logic [3:0]     pendingNibble, pendingNibbleNext;
  logic [3:0]     blockNext;
  logic           validNext, startNext, burstNext;

  logic           push, pop;
  logic [7:0]     fifoData;
  logic [CW-1:0]  fifoCount, fifoCountNext;
  logic           fifoEmpty, lastSample;
  logic [3:0]     firstNibble, secondNibble;

  assign push = ipDataValid && opDataReady;

  qamByteFifo #(.DEPTH(FIFO_DEPTH)) byteFifo (
    .ipClk       (ipClk),
    .ipReset     (ipReset),
    .ipPush      (push),
    .ipData      (ipData),
    .ipPop       (pop),
    .opData      (fifoData),
    .opCount     (fifoCount),
    .opCountNext (fifoCountNext)
  );

  assign fifoEmpty    = (fifoCount == '0);
  assign lastSample   = (sampleCount == LAST_SAMPLE);
  assign firstNibble  = MSB_FIRST ? fifoData[7:4] : fifoData[3:0];
  assign secondNibble = MSB_FIRST ? fifoData[3:0] : fifoData[7:4];

  // With ipEnable low nothing advances; only the per-cycle strobes drop to 0.
  always_comb begin
    stateNext         = state;
    sampleCountNext   = sampleCount;
    pendingNibbleNext = pendingNibble;
    blockNext         = opQAMBlock;
    validNext         = 1'b0;
    startNext         = 1'b0;
    burstNext         = 1'b0;
    pop               = 1'b0;
    if (ipEnable) begin
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            pop               = 1'b1;
            stateNext         = FIRST;
            sampleCountNext   = '0;
            blockNext         = firstNibble;
            pendingNibbleNext = secondNibble;
            validNext         = 1'b1;
            startNext         = 1'b1;
          end
        end
        FIRST: begin
          validNext = 1'b1;
          if (lastSample) begin
            stateNext       = SECOND;
            sampleCountNext = '0;
            blockNext       = pendingNibble;
            startNext       = 1'b1;
          end else begin
            sampleCountNext = sampleCount + 1'b1;
          end
        end
        SECOND: begin
          if (!lastSample) begin
            validNext       = 1'b1;
            sampleCountNext = sampleCount + 1'b1;
          end else if (!fifoEmpty) begin
            // Next byte already buffered: chain into it without a gap cycle.
            pop               = 1'b1;
            stateNext         = FIRST;
            sampleCountNext   = '0;
            blockNext         = firstNibble;
            pendingNibbleNext = secondNibble;
            validNext         = 1'b1;
            startNext         = 1'b1;
          end else begin
            stateNext       = IDLE;
            sampleCountNext = '0;
            blockNext       = 4'h0;
            burstNext       = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state           <= IDLE;
      sampleCount     <= '0;
      pendingNibble   <= 4'h0;
      opQAMBlock      <= 4'h0;
      opQAMBlockValid <= 1'b0;
      opSymbolStart   <= 1'b0;
      opBurstEnd      <= 1'b0;
      opDataReady     <= 1'b0;
    end else begin
      state           <= stateNext;
      sampleCount     <= sampleCountNext;
      pendingNibble   <= pendingNibbleNext;
      opQAMBlock      <= blockNext;
      opQAMBlockValid <= validNext;
      opSymbolStart   <= startNext;
      opBurstEnd      <= burstNext;
      opDataReady     <= (fifoCountNext < CW'(FIFO_DEPTH));
    end
  end
endmodule

// File: doc/qam_symbol_source.md
# qam_symbol_source

Byte-to-symbol front end for the 16-QAM modulator path. It buffers bytes arriving from the framing logic, splits each byte into two 4-bit symbols and holds each symbol stable for a fixed number of carrier samples. Its outputs drive the QAM stage's `ipQAMBlock` and `ipQAMBlockValid` inputs directly, and it sits between the packet source and the QAM stage.

## Interface
- `SAMPLES_PER_SYMBOL`, 8: clocks (carrier samples) each symbol is held; legal range 2–256.
- `FIFO_DEPTH`, 4: byte buffer depth; power of two, 2–16.
- `MSB_FIRST`, 1: 1 sends `byte[7:4]` first; 0 sends `byte[3:0]` first.

- `ipClk` in 1: system clock; all logic rises on this edge.
- `ipReset` in 1: asynchronous, active-high reset.
- `ipData` in 8: byte to transmit.
- `ipDataValid` in 1: `ipData` is valid.
- `opDataReady` out 1: the buffer can accept a byte this cycle.
- `ipEnable` in 1: advance enable; low freezes symbol timing.
- `opQAMBlock` out 4: current symbol, to the QAM stage.
- `opQAMBlockValid` out 1: `opQAMBlock` is valid this cycle.
- `opSymbolStart` out 1: one-cycle pulse on the first sample of each symbol.
- `opBurstEnd` out 1: one-cycle pulse when the stream drains and output goes idle.

## Operation
- **Reset values:** all outputs are 0. FIFO is empty, FSM is IDLE, sample counter is 0. Assertion takes effect immediately and asynchronously, including mid-symbol. All buffered data is discarded.
- **Input handshake:**
  - A byte is accepted on any edge where `ipDataValid && opDataReady`.
  - `opDataReady` is a registered output, equal to "FIFO count < `FIFO_DEPTH`". It is independent of `ipEnable`.
  - `ipData` must hold while `ipDataValid` is high and `opDataReady` is low.
- **FIFO:**
  - Circular buffer; read and write pointers wrap modulo `FIFO_DEPTH`.
  - A push and a pop on the same edge leave the count unchanged. This is legal at full: the pop frees a slot, and `opDataReady` stays low for that cycle because it is registered.
- **FSM states:** IDLE, FIRST, SECOND. All transitions require `ipEnable = 1`.
  - IDLE → FIRST: FIFO is non-empty. Pop a byte into the shift register, drive the first nibble, set counter to 0, pulse `opSymbolStart`.
  - FIRST → SECOND: counter = `SAMPLES_PER_SYMBOL`−1. Drive the second nibble, reset the counter, pulse `opSymbolStart`.
  - SECOND → FIRST: counter = `SAMPLES_PER_SYMBOL`−1 and FIFO non-empty. Pop the next byte with no gap cycle.
  - SECOND → IDLE: counter = `SAMPLES_PER_SYMBOL`−1 and FIFO empty. `opQAMBlockValid` goes to 0, `opQAMBlock` goes to 0, pulse `opBurstEnd`.
  - Otherwise the counter increments.
- **Output while active:** in FIRST or SECOND with `ipEnable = 1`, `opQAMBlockValid` = 1.
- **Pause (`ipEnable = 0`):**
  - Counter, FSM and `opQAMBlock` hold.
  - `opQAMBlockValid`, `opSymbolStart` and `opBurstEnd` are 0.
  - When enable returns, the remaining sample count of the interrupted symbol is delivered; no symbol restart.
  - A symbol that started just before the pause does not pulse `opSymbolStart` again on resume.
- **Widths:** counter is `$clog2(SAMPLES_PER_SYMBOL)` bits; FIFO count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- **Latency:**
  - Byte presented and accepted in cycle 0 with FIFO empty, FSM IDLE and `ipEnable = 1` → `opQAMBlockValid` = 1 and `opSymbolStart` = 1 in cycle 2.
  - One byte occupies exactly 2×`SAMPLES_PER_SYMBOL` valid cycles.
- **Continuous stream:** when the next byte is already buffered, valid stays high across byte boundaries.
- **Throughput:** sustained input of 1 byte per 2×`SAMPLES_PER_SYMBOL` enabled cycles.
- **`opBurstEnd`:** asserted in the first cycle where valid has dropped to 0.
- **Registered outputs:** all outputs are registered; none depends combinationally on the inputs.

## Test plan
- **Single byte:** `SAMPLES_PER_SYMBOL`=8, `MSB_FIRST`=1, single byte 0xA5 in cycle 0.
  - Required: `opQAMBlock`=4'hA with valid in cycles 2–9, then 4'h5 in cycles 10–17.
  - Required: `opSymbolStart` pulses in cycles 2 and 10; valid=0 and `opBurstEnd`=1 in cycle 18.
- **Back-to-back bytes:** bytes 0x12, 0x34, 0x56 offered back-to-back.
  - Required: symbols 1,2,3,4,5,6, 8 cycles each, valid continuously high for 48 cycles.
  - Required: exactly one `opBurstEnd`.
- **Full buffer:** `ipEnable`=0, 5 bytes offered (`FIFO_DEPTH`=4).
  - Required: 4 accepted; `opDataReady`=0 after the 4th; no output valid.
  - Then raise `ipEnable`. Required: the 5th byte is accepted after the first pop; 10 symbols total, in order.
- **Pause mid-symbol:** drop `ipEnable` for 5 cycles after 3 samples of symbol 4'hA.
  - Required: valid=0 during the pause; on resume, 5 more 4'hA samples, then 4'h5.
- **Reset mid-operation:** assert `ipReset` mid-symbol with 2 bytes buffered.
  - Required: all outputs 0 immediately.
  - Required: after release, nothing is emitted until new data arrives, and `opDataReady`=1.
- **LSB-first order:** `MSB_FIRST`=0, byte 0xC3.
  - Required: 4'h3 then 4'hC, 8 cycles each.
